lsu_ram_bridge: RTL and testbench

//   Load/store front-end directly upstream of the word-wide data RAM. Accepts one byte/half/word

---
 rtl/lsu_ram_bridge_pkg.sv | 26 ++
 rtl/lsu_ram_bridge_if.sv | 26 ++
 rtl/lsu_align.sv | 40 ++++
 rtl/lsu_ram_bridge.sv | 105 ++++++++++
 tb/tb_lsu_ram_bridge.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_ram_bridge_pkg.sv
// rtl/lsu_ram_bridge_pkg.sv - shared types, size codes and fault check for the LSU/RAM bridge
package lsu_ram_bridge_pkg;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_RD   = 2'b01,
    LSU_WR   = 2'b10,
    LSU_RESP = 2'b11
  } lsu_state_t;

  // Size 2'b11 is reserved and always faults
  function automatic logic lsu_fault(input logic [1:0] size, input logic [31:0] addr,
                                     input logic [3:0] region);
    logic bad;
    bad = (size == 2'b11) ||
          ((size == LSU_SIZE_H) && addr[0]) ||
          ((size == LSU_SIZE_W) && (addr[1:0] != 2'b00)) ||
          (addr[31:28] != region);
    return bad;
  endfunction

endpackage

// File: rtl/lsu_ram_bridge_if.sv
// rtl/lsu_ram_bridge_if.sv - core-side request/response bundle of the LSU/RAM bridge
interface lsu_ram_bridge_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational load lane extract/extend and store lane merge
module lsu_align
  import lsu_ram_bridge_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_ram_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = i_ram_word[8*i_off +: 8];
    w_half   = i_off[1] ? i_ram_word[31:16] : i_ram_word[15:0];
    o_load   = i_ram_word;
    o_merged = i_wdata;
    case (i_size)
      LSU_SIZE_B: begin
        o_load   = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
        o_merged = i_ram_word;
        o_merged[8*i_off +: 8] = i_wdata[7:0];
      end
      LSU_SIZE_H: begin
        o_load   = {{16{w_half[15] & ~i_unsigned}}, w_half};
        o_merged = i_off[1] ? {i_wdata[15:0], i_ram_word[15:0]}
                            : {i_ram_word[31:16], i_wdata[15:0]};
      end
      default: begin
        o_load   = i_ram_word;
        o_merged = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ram_bridge.sv
// rtl/lsu_ram_bridge.sv - single-outstanding load/store front-end to a word-wide RAM
module lsu_ram_bridge
  import lsu_ram_bridge_pkg::*;
#(
  parameter logic [3:0] REGION = 4'h0
) (
  input  logic                    clk,
  input  logic                    rst,
  lsu_ram_bridge_if.slave         bus,
  output logic                    ram_we_o,
  output logic [31:0]             ram_addr_o,
  output logic [31:0]             ram_wdata_o,
  input  logic [31:0]             ram_rdata_i
);

  lsu_state_t  r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merged;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] w_load;
  logic [31:0] w_merged;

  lsu_align u_align (
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_off      (r_addr[1:0]),
    .i_ram_word (ram_rdata_i),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= LSU_IDLE;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_merged   <= 32'h0;
      r_rdata    <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (bus.req_valid_i) begin
            r_we       <= bus.req_we_i;
            r_size     <= bus.req_size_i;
            r_unsigned <= bus.req_unsigned_i;
            r_addr     <= bus.req_addr_i;
            r_wdata    <= bus.req_wdata_i;
            r_rdata    <= 32'h0;
            r_err      <= 1'b0;
            if (lsu_fault(bus.req_size_i, bus.req_addr_i, REGION)) begin
              r_err   <= 1'b1;
              r_state <= LSU_RESP;
            end else if (bus.req_we_i && (bus.req_size_i == LSU_SIZE_W)) begin
              r_merged <= bus.req_wdata_i;
              r_state  <= LSU_WR;
            end else begin
              // loads and sub-word stores both need the current RAM word first
              r_state <= LSU_RD;
            end
          end
        end
        LSU_RD: begin
          if (r_we) begin
            r_merged <= w_merged;
            r_state  <= LSU_WR;
          end else begin
            r_rdata <= w_load;
            r_state <= LSU_RESP;
          end
        end
        LSU_WR: begin
          r_rdata <= 32'h0;
          r_state <= LSU_RESP;
        end
        LSU_RESP: begin
          if (bus.rsp_ready_i) begin
            r_state <= LSU_IDLE;
          end
        end
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

  // Strobes come straight off the state register so reset kills a write asynchronously
  assign ram_we_o        = (r_state == LSU_WR);
  assign ram_addr_o      = {r_addr[31:2], 2'b00};
  assign ram_wdata_o     = r_merged;
  assign bus.req_ready_o = (r_state == LSU_IDLE);
  assign bus.rsp_valid_o = (r_state == LSU_RESP);
  assign bus.rsp_rdata_o = r_rdata;
  assign bus.rsp_err_o   = r_err;

endmodule

// File: tb/tb_lsu_ram_bridge.sv
// tb/tb_lsu_ram_bridge.sv - scoreboard bench for lsu_ram_bridge with a byte-level reference memory
module tb_lsu_ram_bridge;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wes;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem   [0:1023];
  logic [7:0]  ref_b [0:4095];
  exp_t        sb_q  [$];

  int n_cmp;
  int n_bad;

  lsu_ram_bridge_if bus ();

  lsu_ram_bridge #(.REGION(4'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr[11:2]];
  always @(posedge clk) if (ram_we) mem[ram_addr[11:2]] <= ram_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic ref_fault(input logic [1:0] size, input logic [31:0] a);
    if (a[31:28] != 4'h0) return 1'b1;
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1) return a[0];
    if (size == 2'd2) return a[1:0] != 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                          input logic [31:0] a);
    logic [11:0] i;
    logic [7:0]  b0, b1, b2, b3;
    i  = a[11:0];
    b0 = ref_b[i];
    b1 = ref_b[i + 12'd1];
    b2 = ref_b[i + 12'd2];
    b3 = ref_b[i + 12'd3];
    if (size == 2'd0) return uns ? {24'h0, b0} : {{24{b0[7]}}, b0};
    if (size == 2'd1) return uns ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
    return {b3, b2, b1, b0};
  endfunction

  task automatic push_exp(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    if (ref_fault(size, a)) begin
      e = '{rdata: 32'h0, err: 1'b1, lat: 1, wes: 0};
    end else if (!we) begin
      e = '{rdata: ref_load(size, uns, a), err: 1'b0, lat: 2, wes: 0};
    end else begin
      for (int k = 0; k < (1 << size); k++) ref_b[a[11:0] + 12'(k)] = wd[8*k +: 8];
      e = '{rdata: 32'h0, err: 1'b0, lat: (size == 2'd2) ? 2 : 3, wes: 1};
    end
    sb_q.push_back(e);
  endtask

  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input int hold);
    int   lat;
    int   wes;
    int   guard;
    exp_t e;
    logic [31:0] held;
    guard = 0;
    @(negedge clk);
    while (!bus.req_ready_o && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready_o) chk({tag, " ready_timeout"}, 32'd0, 32'd1);
    push_exp(we, size, uns, a, wd);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = we;
    bus.req_size_i     = size;
    bus.req_unsigned_i = uns;
    bus.req_addr_i     = a;
    bus.req_wdata_i    = wd;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    lat = 0;
    wes = 0;
    do begin
      @(negedge clk);
      lat++;
      if (ram_we) wes++;
    end while (!bus.rsp_valid_o && lat < 10);
    e = sb_q.pop_front();
    chk({tag, " valid"}, {31'd0, bus.rsp_valid_o}, 32'd1);
    chk({tag, " lat"}, lat, e.lat);
    chk({tag, " rdata"}, bus.rsp_rdata_o, e.rdata);
    chk({tag, " err"}, {31'd0, bus.rsp_err_o}, {31'd0, e.err});
    chk({tag, " we_pulses"}, wes, e.wes);
    held = bus.rsp_rdata_o;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, " hold_valid"}, {31'd0, bus.rsp_valid_o}, 32'd1);
      chk({tag, " hold_rdata"}, bus.rsp_rdata_o, held);
      chk({tag, " hold_ready"}, {31'd0, bus.req_ready_o}, 32'd0);
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready_i = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4096; i++) ref_b[i] = 8'h0;
    bus.req_valid_i    = 1'b0;
    bus.req_we_i       = 1'b0;
    bus.req_size_i     = 2'b00;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i     = 32'h0;
    bus.req_wdata_i    = 32'h0;
    bus.rsp_ready_i    = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
    chk("rst rsp_rdata", bus.rsp_rdata_o, 32'd0);
    chk("rst rsp_err", {31'd0, bus.rsp_err_o}, 32'd0);
    chk("rst ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst ram_addr", ram_addr, 32'd0);
    chk("rst ram_wdata", ram_wdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst req_ready", {31'd0, bus.req_ready_o}, 32'd1);

    do_req("t1 sw", 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 0);
    do_req("t1 lw", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);

    do_req("t2 sw", 1'b1, 2'd2, 1'b0, 32'h200, 32'h11223344, 0);
    do_req("t2 sb", 1'b1, 2'd0, 1'b0, 32'h201, 32'hFFFFFFAA, 0);
    do_req("t2 lw", 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 0);
    chk("t2 lw literal", 32'h1122AA44, ref_load(2'd2, 1'b0, 32'h200));

    do_req("t3 sw", 1'b1, 2'd2, 1'b0, 32'h300, 32'h8000F0FF, 0);
    do_req("t3 lb", 1'b0, 2'd0, 1'b0, 32'h300, 32'h0, 0);
    do_req("t3 lbu", 1'b0, 2'd0, 1'b1, 32'h300, 32'h0, 0);
    do_req("t3 lh", 1'b0, 2'd1, 1'b0, 32'h302, 32'h0, 0);
    do_req("t3 lhu", 1'b0, 2'd1, 1'b1, 32'h302, 32'h0, 0);
    do_req("t3 lb3", 1'b0, 2'd0, 1'b0, 32'h301, 32'h0, 0);
    do_req("t3 sh_hi", 1'b1, 2'd1, 1'b0, 32'h302, 32'h0000_7E5A, 0);
    do_req("t3 lw2", 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 0);

    do_req("t4 lw_mis", 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 0);
    do_req("t4 sh_mis", 1'b1, 2'd1, 1'b0, 32'h103, 32'h1234, 0);
    do_req("t4 sw_reg", 1'b1, 2'd2, 1'b0, 32'h1000_0000, 32'hCAFEF00D, 0);
    do_req("t4 size3", 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0);
    do_req("t4 lw_chk", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);

    do_req("t5 hold", 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 5);

    // t6: reset lands while the sub-word store sits in WR
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b1;
    bus.req_size_i  = 2'd1;
    bus.req_addr_i  = 32'h202;
    bus.req_wdata_i = 32'h5555;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6 in_wr", {31'd0, ram_we}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("t6 we_drop", {31'd0, ram_we}, 32'd0);
    chk("t6 rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
    chk("t6 ram_addr", ram_addr, 32'd0);
    @(negedge clk);
    chk("t6 ram_word", mem[32'h200 >> 2], ref_load(2'd2, 1'b0, 32'h200));
    rst = 1'b1;
    @(negedge clk);
    chk("t6 idle", {31'd0, bus.req_ready_o}, 32'd1);
    do_req("t6 lw", 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 0);

    chk("sb empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
